// File: rtl/alu_uart_requester.sv
// Host-side initiator for the UART ALU protocol: sends A, B, OP bytes to the TX FIFO, then returns the one-byte RX result.
// Define ALU_REQ_TIMEOUT_EN to add a WAIT_RES watchdog of TIMEOUT_CYC clocks that pulses o_timeout.
module alu_uart_requester #(
  parameter int DBIT        = 8,
  parameter int NB_OP       = 6,
  parameter int NB_AB       = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [NB_AB-1:0] i_data_a,
  input  logic [NB_AB-1:0] i_data_b,
  input  logic [NB_OP-1:0] i_op,
  input  logic             tx_full,
  input  logic             rx_empty,
  input  logic [DBIT-1:0]  r_data,
  output logic [DBIT-1:0]  w_data,
  output logic             wr_uart,
  output logic             rd_uart,
  output logic [NB_AB-1:0] o_result,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_timeout
);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES, DONE} state_t;

  state_t           state_q, state_d;
  logic [NB_AB-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [NB_OP-1:0] op_q, op_d;
  logic [DBIT-1:0]  w_dec;
  logic             wr_dec, rd_dec;

`ifdef ALU_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    w_dec   = '0;
    wr_dec  = 1'b0;
    rd_dec  = 1'b0;
`ifdef ALU_REQ_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A stray RX byte is drained before any new request is accepted.
        if (!rx_empty) begin
          rd_dec = 1'b1;
        end else if (i_start) begin
          a_d     = i_data_a;
          b_d     = i_data_b;
          op_d    = i_op;
          state_d = SEND_A;
        end
      end
      SEND_A: begin
        w_dec = DBIT'(a_q);
        if (!tx_full) begin
          wr_dec  = 1'b1;
          state_d = SEND_B;
        end
      end
      SEND_B: begin
        w_dec = DBIT'(b_q);
        if (!tx_full) begin
          wr_dec  = 1'b1;
          state_d = SEND_OP;
        end
      end
      SEND_OP: begin
        w_dec = DBIT'(op_q);
        if (!tx_full) begin
          wr_dec  = 1'b1;
          state_d = WAIT_RES;
`ifdef ALU_REQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT_RES: begin
        if (!rx_empty) begin
          rd_dec  = 1'b1;
          res_d   = NB_AB'(r_data);
          state_d = DONE;
`ifdef ALU_REQ_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
`ifdef ALU_REQ_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
`ifdef ALU_REQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // Strobes are masked during reset so an aborted transaction pushes/pops nothing more.
  assign wr_uart  = wr_dec & ~i_reset;
  assign rd_uart  = rd_dec & ~i_reset;
  assign w_data   = w_dec;
  assign o_result = res_q;
  assign o_done   = (state_q == DONE);
  assign o_busy   = (state_q != IDLE) && (state_q != DONE);

`ifdef ALU_REQ_TIMEOUT_EN
  assign o_timeout = to_q;
`else
  assign o_timeout = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_alu_uart_requester.sv
// Directed bench for alu_uart_requester: request framing, TX backpressure, stray RX drain, reset abort, busy-time start.
module tb_alu_uart_requester;

  logic       clock = 1'b0;
  logic       i_reset, i_start, tx_full, rx_empty;
  logic [7:0] i_data_a, i_data_b, r_data;
  logic [5:0] i_op;
  logic [7:0] w_data, o_result;
  logic       wr_uart, rd_uart, o_done, o_busy, o_timeout;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_pop = 0;
  int         pop_base;
  logic [7:0] tx_q[$];

  alu_uart_requester #(.DBIT(8), .NB_OP(6), .NB_AB(8), .TIMEOUT_CYC(16)) dut (
    .clock(clock), .i_reset(i_reset), .i_start(i_start),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_op(i_op),
    .tx_full(tx_full), .rx_empty(rx_empty), .r_data(r_data),
    .w_data(w_data), .wr_uart(wr_uart), .rd_uart(rd_uart),
    .o_result(o_result), .o_done(o_done), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_uart === 1'b1) tx_q.push_back(w_data);
    if (rd_uart === 1'b1) n_pop++;
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tx(input string tag, input int n, input logic [7:0] b0,
                        input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp_b[3];
    logic [7:0] got;
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    chk({tag, "_count"}, tx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp_b[i]});
    end
    tx_q.delete();
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; tx_full = 1'b0; rx_empty = 1'b1;
    i_data_a = '0; i_data_b = '0; i_op = '0; r_data = '0;
    cyc(); cyc();
    #1;
    chk("rst_wr", wr_uart, 0);   chk("rst_rd", rd_uart, 0);
    chk("rst_busy", o_busy, 0);  chk("rst_done", o_done, 0);
    chk("rst_res", o_result, 0); chk("rst_wdata", w_data, 0);
    chk("rst_tmo", o_timeout, 0);
    i_reset = 1'b0;

    // 1: basic request, minimum latency
    i_data_a = 8'h05; i_data_b = 8'h03; i_op = 6'b100000; i_start = 1'b1;
    #1 chk("t1_busy_c0", o_busy, 0);
    cyc(); i_start = 1'b0;
    #1 chk("t1_wr_c1", wr_uart, 1); chk("t1_w_c1", w_data, 8'h05); chk("t1_busy_c1", o_busy, 1);
    cyc();
    #1 chk("t1_wr_c2", wr_uart, 1); chk("t1_w_c2", w_data, 8'h03);
    cyc();
    #1 chk("t1_wr_c3", wr_uart, 1); chk("t1_w_c3", w_data, 8'h20);
    cyc(); rx_empty = 1'b0; r_data = 8'h08;
    #1 chk("t1_wr_c4", wr_uart, 0); chk("t1_rd_c4", rd_uart, 1); chk("t1_busy_c4", o_busy, 1);
    cyc(); rx_empty = 1'b1;
    #1 chk("t1_done", o_done, 1); chk("t1_res", o_result, 8'h08);
    chk("t1_busy_done", o_busy, 0); chk("t1_rd_done", rd_uart, 0);
    cyc();
    #1 chk("t1_done_clr", o_done, 0);
    chk_tx("t1_tx", 3, 8'h05, 8'h03, 8'h20);

    // 2: TX backpressure during SEND_B
    i_data_a = 8'h05; i_data_b = 8'h03; i_op = 6'b100000; i_start = 1'b1;
    cyc(); i_start = 1'b0;
    cyc(); tx_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t2_hold_wr%0d", k), wr_uart, 0);
      chk($sformatf("t2_hold_w%0d", k), w_data, 8'h03);
      cyc();
    end
    tx_full = 1'b0;
    #1 chk("t2_rel_wr", wr_uart, 1); chk("t2_rel_w", w_data, 8'h03);
    cyc();
    #1 chk("t2_op_w", w_data, 8'h20);
    cyc(); rx_empty = 1'b0; r_data = 8'h08;
    cyc(); rx_empty = 1'b1;
    #1 chk("t2_done", o_done, 1); chk("t2_res", o_result, 8'h08);
    cyc();
    chk_tx("t2_tx", 3, 8'h05, 8'h03, 8'h20);

    // 3: stray RX byte drained in IDLE before the request goes out
    pop_base = n_pop;
    i_data_a = 8'h07; i_data_b = 8'h02; i_op = 6'h01; i_start = 1'b1;
    rx_empty = 1'b0; r_data = 8'hAA;
    #1 chk("t3_stray_rd", rd_uart, 1); chk("t3_stray_wr", wr_uart, 0);
    cyc(); rx_empty = 1'b1;
    #1 chk("t3_idle_busy", o_busy, 0); chk("t3_idle_wr", wr_uart, 0);
    cyc(); i_start = 1'b0;
    #1 chk("t3_sa_wr", wr_uart, 1); chk("t3_sa_w", w_data, 8'h07);
    cyc(); cyc(); cyc(); rx_empty = 1'b0; r_data = 8'h09;
    cyc(); rx_empty = 1'b1;
    #1 chk("t3_done", o_done, 1); chk("t3_res", o_result, 8'h09);
    cyc();
    chk("t3_pops", n_pop - pop_base, 2);
    chk_tx("t3_tx", 3, 8'h07, 8'h02, 8'h01);

    // 4: reset in SEND_OP aborts without pushing OP
    i_data_a = 8'h12; i_data_b = 8'h34; i_op = 6'h15; i_start = 1'b1;
    cyc(); i_start = 1'b0;
    cyc(); cyc();
    i_reset = 1'b1;
    #1 chk("t4_rst_wr", wr_uart, 0);
    cyc();
    #1 chk("t4_busy", o_busy, 0); chk("t4_res", o_result, 0); chk("t4_w", w_data, 0);
    chk("t4_done", o_done, 0); chk("t4_rd", rd_uart, 0);
    i_reset = 1'b0;
    cyc();
    #1 chk("t4_idle_wr", wr_uart, 0);
    chk_tx("t4_tx", 2, 8'h12, 8'h34, 8'h00);

    // 6: start while waiting for the result is ignored
    i_data_a = 8'h05; i_data_b = 8'h03; i_op = 6'b100000; i_start = 1'b1;
    cyc(); i_start = 1'b0;
    cyc(); cyc(); cyc();
    i_data_a = 8'hFF; i_data_b = 8'hEE; i_op = 6'h3F;
    for (int k = 0; k < 3; k++) begin
      i_start = ~i_start;
      #1 chk($sformatf("t6_busy%0d", k), o_busy, 1);
      chk($sformatf("t6_wr%0d", k), wr_uart, 0);
      chk($sformatf("t6_tmo%0d", k), o_timeout, 0);
      cyc();
    end
    i_start = 1'b0; rx_empty = 1'b0; r_data = 8'h08;
    cyc(); rx_empty = 1'b1;
    #1 chk("t6_done", o_done, 1); chk("t6_res", o_result, 8'h08);
    cyc(); cyc(); cyc();
    #1 chk("t6_idle_busy", o_busy, 0);
    chk_tx("t6_tx", 3, 8'h05, 8'h03, 8'h20);

`ifdef ALU_REQ_TIMEOUT_EN
    // 5: watchdog expiry with no reply
    i_data_a = 8'h01; i_data_b = 8'h01; i_op = 6'h01; i_start = 1'b1;
    cyc(); i_start = 1'b0;
    cyc(); cyc(); cyc();
    for (int k = 0; k < 15; k++) cyc();
    #1 chk("t5_pre_tmo", o_timeout, 0); chk("t5_pre_busy", o_busy, 1);
    cyc();
    #1 chk("t5_tmo", o_timeout, 1); chk("t5_busy", o_busy, 0);
    chk("t5_done", o_done, 0); chk("t5_res", o_result, 8'h08);
    cyc();
    #1 chk("t5_tmo_clr", o_timeout, 0);
    chk_tx("t5_tx", 3, 8'h01, 8'h01, 8'h01);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
